// File: rtl/count_monitor.sv
// Watches an upstream free-running counter: wrap/epoch tracking, compare match,
// and a held snapshot with ready handshake. Define COUNT_MONITOR_STEP_CHECK_EN for the step checker.
module count_monitor #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   cnt_in,
  input  logic [WIDTH-1:0]   match_val,
  input  logic               snap_req,
  input  logic               snap_rdy,
  input  logic               err_clr,
  output logic               wrap_pulse,
  output logic               match_pulse,
  output logic [EPOCH_W-1:0] epoch,
  output logic               snap_vld,
  output logic [WIDTH-1:0]   snap_cnt,
  output logic [EPOCH_W-1:0] snap_epoch,
  output logic               err_step
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q;
  logic               primed_q;
  logic               wrap_q, wrap_d;
  logic               match_q, match_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [WIDTH-1:0]   snap_cnt_q, snap_cnt_d;
  logic [EPOCH_W-1:0] snap_epoch_q, snap_epoch_d;

  always_comb begin
    wrap_d       = primed_q && (prev_q == '1) && (cnt_in == '0);
    epoch_d      = epoch_q + EPOCH_W'(wrap_d);
    match_d      = (cnt_in == match_val);
    state_d      = state_q;
    snap_cnt_d   = snap_cnt_q;
    snap_epoch_d = snap_epoch_q;
    case (state_q)
      IDLE: begin
        // Snapshot sees the epoch including a wrap detected at this same edge.
        if (snap_req) begin
          state_d      = HOLD;
          snap_cnt_d   = cnt_in;
          snap_epoch_d = epoch_d;
        end
      end
      HOLD: begin
        if (snap_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      wrap_q       <= 1'b0;
      match_q      <= 1'b0;
      epoch_q      <= '0;
      snap_cnt_q   <= '0;
      snap_epoch_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= cnt_in;
      primed_q     <= 1'b1;
      wrap_q       <= wrap_d;
      match_q      <= match_d;
      epoch_q      <= epoch_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_epoch_q <= snap_epoch_d;
    end
  end

`ifdef COUNT_MONITOR_STEP_CHECK_EN
  logic err_q, err_d;

  // A new error takes priority over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (primed_q && (cnt_in != prev_q + WIDTH'(1))) err_d = 1'b1;
    else if (err_clr)                              err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_step = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_step       = 1'b0;
`endif

  assign wrap_pulse  = wrap_q;
  assign match_pulse = match_q;
  assign epoch       = epoch_q;
  assign snap_vld    = (state_q == HOLD);
  assign snap_cnt    = snap_cnt_q;
  assign snap_epoch  = snap_epoch_q;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor (WIDTH=4, EPOCH_W=8); honours COUNT_MONITOR_STEP_CHECK_EN.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in, match_val;
  logic       snap_req, snap_rdy, err_clr;
  logic       wrap_pulse, match_pulse, snap_vld, err_step;
  logic [7:0] epoch, snap_epoch;
  logic [3:0] snap_cnt;

  count_monitor #(.WIDTH(4), .EPOCH_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .match_val(match_val),
    .snap_req(snap_req), .snap_rdy(snap_rdy), .err_clr(err_clr),
    .wrap_pulse(wrap_pulse), .match_pulse(match_pulse), .epoch(epoch),
    .snap_vld(snap_vld), .snap_cnt(snap_cnt), .snap_epoch(snap_epoch),
    .err_step(err_step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wrap;
    logic       match;
    logic [7:0] epoch;
    logic       vld;
    logic [3:0] scnt;
    logic [7:0] sepoch;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_wrap = 0, n_match = 0, n_vld = 0;
  bit   seen_roll = 1'b0;

`ifdef COUNT_MONITOR_STEP_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // Reference state for the scoreboard
  logic [3:0] m_prev = '0;
  logic       m_primed = 1'b0;
  logic [7:0] m_epoch = '0;
  logic       m_vld = 1'b0;
  logic [3:0] m_scnt = '0;
  logic [7:0] m_sepoch = '0;
  logic       m_err = 1'b0;
  logic [3:0] nxt = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_primed = 1'b0; m_epoch = '0; m_vld = 1'b0;
    m_scnt = '0; m_sepoch = '0; m_err = 1'b0;
  endtask

  task automatic step(input logic [3:0] c, input logic req, input logic rdy, input logic clr);
    exp_t e;
    @(negedge clk);
    cnt_in = c; snap_req = req; snap_rdy = rdy; err_clr = clr;
    @(posedge clk);
    e.wrap  = m_primed && (m_prev == 4'hF) && (c == 4'h0);
    m_epoch = m_epoch + {7'd0, e.wrap};
    e.match = (c == match_val);
    if (!m_vld) begin
      if (req) begin m_vld = 1'b1; m_scnt = c; m_sepoch = m_epoch; end
    end else if (rdy) begin
      m_vld = 1'b0;
    end
    if (ERR_ON) begin
      if (m_primed && (c != 4'(m_prev + 4'd1))) m_err = 1'b1;
      else if (clr)                             m_err = 1'b0;
    end
    m_primed = 1'b1;
    m_prev   = c;
    e.epoch = m_epoch; e.vld = m_vld; e.scnt = m_scnt; e.sepoch = m_sepoch; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step(nxt, 1'b0, 1'b0, 1'b0);
      nxt++;
    end
  endtask

  // Monitor: outputs are presented every cycle, compared 2 time units after the edge
  initial begin : monitor
    exp_t e;
    logic [7:0] last_ep = '0;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wrap_pulse",  wrap_pulse,  e.wrap);
        chk("match_pulse", match_pulse, e.match);
        chk("epoch",       epoch,       e.epoch);
        chk("snap_vld",    snap_vld,    e.vld);
        chk("snap_cnt",    snap_cnt,    e.scnt);
        chk("snap_epoch",  snap_epoch,  e.sepoch);
        chk("err_step",    err_step,    e.err);
        if (wrap_pulse)  n_wrap++;
        if (match_pulse) n_match++;
        if (snap_vld)    n_vld++;
        if (last_ep == 8'd255 && epoch == 8'd0) seen_roll = 1'b1;
        last_ep = epoch;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; cnt_in = '0; match_val = 4'hA;
    snap_req = 1'b0; snap_rdy = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wrap", wrap_pulse, 0);   chk("rst_match", match_pulse, 0);
    chk("rst_epoch", epoch, 0);       chk("rst_vld", snap_vld, 0);
    chk("rst_scnt", snap_cnt, 0);     chk("rst_sepoch", snap_epoch, 0);
    chk("rst_err", err_step, 0);
    rst = 1'b0;

    // Count 0..15,0: one wrap, none on the first 0
    for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    nxt = 4'h1;
    #3;
    chk("wrap_count", n_wrap, 1);
    chk("epoch_after_first_wrap", epoch, 1);

    // Snapshot at cnt=5, epoch=2; req during HOLD ignored; rdy after 3 cycles
    run(20);
    n_vld = 0;
    step(4'h5, 1'b1, 1'b0, 1'b0);
    step(4'h6, 1'b0, 1'b0, 1'b0);
    step(4'h7, 1'b1, 1'b0, 1'b0);
    step(4'h8, 1'b0, 1'b0, 1'b0);
    #3;
    chk("snap_cnt_held", snap_cnt, 5);
    chk("snap_epoch_held", snap_epoch, 2);
    step(4'h9, 1'b1, 1'b1, 1'b0);
    #3;
    chk("snap_vld_after_hs", snap_vld, 0);
    chk("snap_vld_cycles", n_vld, 4);
    step(4'hA, 1'b0, 1'b1, 1'b0);
    nxt = 4'hB;

    // match_val=9 over 48 free-running cycles
    #3;
    match_val = 4'h9;
    n_match = 0;
    run(48);
    #3;
    chk("match_count", n_match, 3);
    chk("epoch_after_match", epoch, 5);

    // Step checker: 3->7 jump, clear, error+clear together
    run(9);
    step(4'h7, 1'b0, 1'b0, 1'b0);
    #3; chk("err_set", err_step, ERR_ON);
    step(4'h8, 1'b0, 1'b0, 1'b0);
    step(4'h9, 1'b0, 1'b0, 1'b0);
    #3; chk("err_sticky", err_step, ERR_ON);
    step(4'hA, 1'b0, 1'b0, 1'b1);
    #3; chk("err_cleared", err_step, 0);
    step(4'hB, 1'b0, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0, 1'b1);
    #3; chk("err_set_wins", err_step, ERR_ON);
    step(4'h0, 1'b0, 1'b0, 1'b1);
    #3; chk("err_clear_on_wrap", err_step, 0);
    chk("epoch_after_err", epoch, 7);
    nxt = 4'h1;

    // 256 wraps: epoch passes 255->0 and lands back at 7
    run(256 * 16);
    #3;
    chk("epoch_after_256_wraps", epoch, 7);
    chk("epoch_rollover_seen", seen_roll, 1);

    // Reset during HOLD abandons the snapshot immediately
    step(4'h1, 1'b1, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0, 1'b0);
    #3; chk("hold_before_rst", snap_vld, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_vld", snap_vld, 0);
    chk("async_rst_epoch", epoch, 0);
    chk("async_rst_sepoch", snap_epoch, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    match_val = 4'h5;
    // First sample 5 after prev=0: prime only, but match fires
    for (int i = 5; i < 9; i++) step(4'(i), 1'b0, 1'b1, 1'b0);
    #3;
    chk("no_vld_after_rst", snap_vld, 0);
    chk("no_err_on_prime", err_step, 0);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the bit width of the consumed count.
REQ-002 SHALL have parameter EPOCH_W, default 8, the bit width of the wrap (epoch) counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-005 SHALL have port cnt_in  input  WIDTH  count value from the upstream synchronous counter; advances by 1 each clk.
REQ-006 SHALL have port match_val  input  WIDTH  compare value for match_pulse.
REQ-007 SHALL have port snap_req  input  1  request to capture a snapshot.
REQ-008 SHALL have port snap_rdy  input  1  consumer accepts the snapshot.
REQ-009 SHALL have port err_clr  input  1  clears err_step.
REQ-010 SHALL have port wrap_pulse  output  1  one-cycle pulse on upstream wrap.
REQ-011 SHALL have port match_pulse  output  1  one-cycle pulse on compare match.
REQ-012 SHALL have port epoch  output  EPOCH_W  number of wraps seen, modulo 2^EPOCH_W.
REQ-013 SHALL have ports snap_vld (output, 1), snap_cnt (output, WIDTH) and snap_epoch (output, EPOCH_W), which carry the snapshot handshake and data.
REQ-014 SHALL have port err_step  output  1  sticky step-error flag (see Configuration).

Function
REQ-015 SHALL register cnt_in every cycle into prev; a primed flag SHALL set on the first edge after reset release.
REQ-016 SHALL detect a wrap at an edge where primed=1, prev = all-ones and cnt_in = 0; that edge SHALL set wrap_pulse=1 for exactly one cycle and increment epoch.
REQ-017 SHALL wrap epoch from 2^EPOCH_W-1 to 0 without a flag.
REQ-018 SHALL set match_pulse=1 for one cycle after every edge where cnt_in == match_val, including the first sample after reset.
REQ-019 SHALL implement snapshot FSM states IDLE and HOLD; snap_vld SHALL be 1 exactly in HOLD.
REQ-020 In IDLE, snap_req=1 at an edge SHALL capture snap_cnt=cnt_in and snap_epoch=epoch value after that edge's update, and SHALL enter HOLD.
REQ-021 In HOLD, snap_cnt and snap_epoch SHALL be stable; snap_req SHALL be ignored (no re-capture, no queueing).
REQ-022 In HOLD, snap_vld=1 and snap_rdy=1 at an edge SHALL return the FSM to IDLE; a snap_req at that same edge SHALL be ignored.
REQ-023 snap_rdy in IDLE SHALL have no effect.
REQ-024 All outputs SHALL be registered; latency from the sampled event to the output is 1 cycle.

Reset
REQ-025 rst=1 SHALL immediately force wrap_pulse=0, match_pulse=0, epoch=0, snap_vld=0, snap_cnt=0, snap_epoch=0, err_step=0, prev=0, primed=0 and FSM=IDLE.
REQ-026 Reset asserted in HOLD SHALL abandon the snapshot; no snap_vld after release until a new snap_req.
REQ-027 The first edge after release SHALL only prime (no wrap and no step check); match and snapshot SHALL operate normally.

Configuration
REQ-028 Macro COUNT_MONITOR_STEP_CHECK_EN SHALL compile in the step checker.
REQ-029 With the macro defined, an edge where primed=1 and cnt_in != prev+1 (mod 2^WIDTH) SHALL set err_step=1; err_step SHALL hold until an edge with err_clr=1.
REQ-030 With the macro defined, an error and err_clr at the same edge SHALL leave err_step=1 (set wins).
REQ-031 Without the macro, err_step SHALL be tied 0, err_clr SHALL be ignored, and no checker logic SHALL exist.

Verification (WIDTH=4, EPOCH_W=8)
REQ-032 Release rst, then cnt_in runs 0..15,0 -> wrap_pulse=1 for one cycle after 0 is sampled following 15, epoch=1; no wrap pulse on the first 0.
REQ-033 Set match_val=9 with a free-running count for 48 cycles -> exactly 3 match_pulse, each 1 cycle after cnt_in=9.
REQ-034 snap_req while cnt_in=5 and epoch=2, with snap_rdy=0 for 3 cycles then 1 -> snap_vld=1 for 4 cycles with snap_cnt=5 and snap_epoch=2 stable; a snap_req in HOLD is ignored; snap_vld=0 after the handshake.
REQ-035 With the macro defined, cnt_in steps 3->7 -> err_step=1 on the next cycle and stays 1 until err_clr; err_clr and a new error at the same edge -> err_step stays 1. Without the macro -> err_step always 0.
REQ-036 Run 256 wraps -> epoch returns 255->0. Assert rst in HOLD -> snap_vld=0 and epoch=0 immediately.
